// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - sequential instruction fetch with credit-limited FIFO, stall and redirect flush
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q [DEPTH];

    logic          req_fire;
    logic          rsp_take;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_base;

    always_comb begin
        // Every in-flight request holds a reserved FIFO slot, so a push can never overflow.
        credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
        redirect_base  = redirect_pc & 32'hFFFF_FFFC;
        imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        id_valid       = !rst && (count_q != '0);
        id_inst        = id_valid ? inst_mem_q[head_q] : 32'h0;
        id_pc          = id_valid ? pc_mem_q[head_q] : 32'h0;

        req_fire = imem_req_valid && imem_req_ready;
        rsp_take = imem_rsp_valid && (outstanding_q != '0);
        pop      = id_valid && id_ready && !redirect_valid;
        push     = rsp_take && (drop_q == '0) && !redirect_valid;

        outstanding_d = outstanding_q;
        case ({req_fire, rsp_take})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d   = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
        drop_d     = (rsp_take && (drop_q != '0)) ? drop_q - CW'(1) : drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        head_d     = pop ? head_q + PW'(1) : head_q;
        tail_d     = push ? tail_q + PW'(1) : tail_q;

        // Everything still in flight after this edge belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            drop_d     = outstanding_d;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_mem_q[tail_q] <= imem_rsp_data;
            pc_mem_q[tail_q]   <= rsp_pc_q;
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer with queue-based memory and stream model
module tb_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        idr;
        logic        exp_req_v;
        logic [31:0] exp_req_addr;
        logic        exp_id_v;
        logic [31:0] exp_id_pc;
    } vec_t;

    req_t        memq[$];
    logic [31:0] fifo[$];
    logic [31:0] exp_fetch;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        drv_rst = 1'b1, drv_redir = 1'b0, drv_idr = 1'b0, drv_ready = 1'b1;
    logic [31:0] drv_rpc = 32'h0;
    int          lat = 1;
    bit          jitter = 1'b0;
    bit          hs_seen, pop_seen;
    logic [31:0] first_hs, first_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit          rsp_v;
        bit          exp_rv;
        bit          pop_m;
        req_t        e;
        @(negedge clk);
        cyc++;
        rst            = drv_rst;
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        id_ready       = drv_idr;
        imem_req_ready = drv_ready;
        if (drv_rst) memq.delete();
        rsp_v = !drv_rst && memq.size() > 0 && memq[0].due <= cyc &&
                (!jitter || $urandom_range(0, 3) != 0);
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_v ? mem_word(memq[0].addr) : $urandom;
        #1;
        if (drv_rst) begin
            chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
            chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
            chk("rst_id_inst", id_inst, 32'h0);
            chk("rst_id_pc", id_pc, 32'h0);
            fifo.delete();
            exp_fetch = RESET_PC;
            return;
        end
        exp_rv = !drv_redir && (fifo.size() + memq.size() < DEPTH);
        chk("id_valid", {31'h0, id_valid}, {31'h0, fifo.size() != 0});
        chk("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
        if (fifo.size() != 0) begin
            chk("id_pc", id_pc, fifo[0]);
            chk("id_inst", id_inst, mem_word(fifo[0]));
        end
        if (exp_rv) chk("req_addr", imem_req_addr, exp_fetch);

        pop_m = fifo.size() != 0 && drv_idr && !drv_redir;
        if (drv_redir) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            fifo.delete();
            exp_fetch = drv_rpc & 32'hFFFF_FFFC;
        end
        if (pop_m) begin
            if (!pop_seen) begin
                pop_seen  = 1'b1;
                first_pop = fifo[0];
            end
            void'(fifo.pop_front());
        end
        if (rsp_v) begin
            e = memq.pop_front();
            if (!e.stale) fifo.push_back(e.addr);
        end
        if (exp_rv && drv_ready) begin
            if (!hs_seen) begin
                hs_seen  = 1'b1;
                first_hs = exp_fetch;
            end
            memq.push_back('{addr: exp_fetch, due: cyc + lat, stale: 1'b0});
            exp_fetch = exp_fetch + 32'd4;
        end
    endtask

    vec_t        tbl[17];
    logic [31:0] held_pc;
    int          n;

    initial begin
        // rst, redir, rpc, id_ready | req_valid, req_addr, id_valid, id_pc  (1-cycle memory, always ready)
        tbl[0]  = '{1, 0, 32'h0,   0, 0, 32'h0,         0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,   1, 1, 32'hFFFF_FFF8, 0, 32'h0};
        tbl[2]  = '{0, 0, 32'h0,   1, 1, 32'hFFFF_FFFC, 0, 32'h0};
        tbl[3]  = '{0, 0, 32'h0,   1, 1, 32'h0,         1, 32'hFFFF_FFF8};
        tbl[4]  = '{0, 0, 32'h0,   1, 1, 32'h4,         1, 32'hFFFF_FFFC};
        tbl[5]  = '{0, 0, 32'h0,   1, 1, 32'h8,         1, 32'h0};
        tbl[6]  = '{0, 0, 32'h0,   0, 1, 32'hC,         1, 32'h4};
        tbl[7]  = '{0, 0, 32'h0,   0, 1, 32'h10,        1, 32'h4};
        tbl[8]  = '{0, 0, 32'h0,   0, 0, 32'h0,         1, 32'h4};
        tbl[9]  = '{0, 0, 32'h0,   0, 0, 32'h0,         1, 32'h4};
        tbl[10] = '{0, 0, 32'h0,   1, 0, 32'h0,         1, 32'h4};
        tbl[11] = '{0, 0, 32'h0,   1, 1, 32'h14,        1, 32'h8};
        tbl[12] = '{0, 0, 32'h0,   1, 1, 32'h18,        1, 32'hC};
        tbl[13] = '{0, 1, 32'h203, 1, 0, 32'h0,         1, 32'h10};
        tbl[14] = '{0, 0, 32'h0,   1, 1, 32'h200,       0, 32'h0};
        tbl[15] = '{0, 0, 32'h0,   1, 1, 32'h204,       0, 32'h0};
        tbl[16] = '{0, 0, 32'h0,   1, 1, 32'h208,       1, 32'h200};

        hs_seen = 1'b0; pop_seen = 1'b0;
        exp_fetch = RESET_PC;
        for (int i = 0; i < 17; i++) begin
            drv_rst = tbl[i].rst; drv_redir = tbl[i].redir; drv_rpc = tbl[i].rpc;
            drv_idr = tbl[i].idr; drv_ready = 1'b1; lat = 1; jitter = 1'b0;
            step();
            chk($sformatf("tbl%0d_req_valid", i), {31'h0, imem_req_valid}, {31'h0, tbl[i].exp_req_v});
            if (tbl[i].exp_req_v) chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].exp_req_addr);
            chk($sformatf("tbl%0d_id_valid", i), {31'h0, id_valid}, {31'h0, tbl[i].exp_id_v});
            if (tbl[i].exp_id_v) chk($sformatf("tbl%0d_id_pc", i), id_pc, tbl[i].exp_id_pc);
        end
        drv_redir = 1'b0;

        // Decode stalls long enough to fill the FIFO; the head must hold.
        drv_idr = 1'b0;
        held_pc = fifo.size() != 0 ? fifo[0] : 32'h0;
        for (int i = 0; i < 10; i++) step();
        chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("stall_id_valid", {31'h0, id_valid}, 32'h1);
        chk("stall_hold_pc", id_pc, held_pc);
        chk("stall_fifo_full", fifo.size(), DEPTH);

        // Reset with a full FIFO, then resume.
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        step();
        chk("post_rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("post_rst_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("post_rst_req_addr", imem_req_addr, RESET_PC);
        drv_idr = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // 3-cycle memory: redirect to 0x100 with two requests in flight.
        drv_rst = 1'b1; step(); drv_rst = 1'b0;
        lat = 3;
        n = 0;
        while (memq.size() != 2 && n < 20) begin
            step();
            n++;
        end
        chk("redir3_setup_outstanding", memq.size(), 2);
        drv_redir = 1'b1; drv_rpc = 32'h100;
        step();
        drv_redir = 1'b0;
        hs_seen = 1'b0; pop_seen = 1'b0;
        n = 0;
        while (!pop_seen && n < 30) begin
            step();
            n++;
        end
        chk("redir3_timeout", {31'h0, pop_seen}, 32'h1);
        chk("redir3_first_req", first_hs, 32'h100);
        chk("redir3_first_id_pc", first_pop, 32'h100);

        // Randomised traffic against the stream model.
        jitter = 1'b1;
        for (int s = 0; s < 40; s++) begin
            lat = $urandom_range(1, 4);
            for (int i = 0; i < 100; i++) begin
                drv_ready = $urandom_range(0, 3) != 0;
                drv_idr   = $urandom_range(0, 3) != 0;
                drv_redir = $urandom_range(0, 39) == 0;
                drv_rpc   = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                drv_rst   = $urandom_range(0, 299) == 0;
                step();
            end
        end
        drv_rst = 1'b0; drv_redir = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Generates sequential PCs and issues requests to instruction memory, which may take several cycles to respond.
- Buffers returned instruction words with their PCs in a DEPTH-entry FIFO and presents them to decode via a valid/ready handshake.
- Supports pipeline stall through id_ready and PC redirect (branch, jump, or CSR trap) with flush of all buffered and in-flight instructions.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch address; bits [1:0] are always 0.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_rsp_valid  input  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- id_valid  output  1  id_inst and id_pc are valid.
- id_inst  output  32  instruction to the decoder.
- id_pc  output  32  PC of id_inst.
- id_ready  input  1  decode consumes the head entry this cycle; low means stall.

Behaviour:
- Reset, while rst is high:
  - fetch_pc and rsp_pc are set to RESET_PC.
  - FIFO count, outstanding and drop are set to 0.
  - imem_req_valid=0, id_valid=0, id_inst=0, id_pc=0.
  - rst overrides every other input, including mid-flight responses.
- Responses that arrive after reset for requests issued before reset are a system error; memory must be reset together with this block.
- Counters: count, outstanding and drop are $clog2(DEPTH)+1 bits wide, range 0..DEPTH.
- Request rule:
  - imem_req_valid = !redirect_valid && (count + outstanding < DEPTH). This credit rule guarantees FIFO space for every response.
  - imem_req_addr = fetch_pc.
  - On handshake (valid && ready): fetch_pc += 4 with 32-bit wrap (FFFF_FFFC -> 0000_0000), and outstanding increments.
  - The address stays stable while valid && !ready. Memory must tolerate request withdrawal when redirect_valid is high.
- Response rule, when imem_rsp_valid is high:
  - outstanding decrements.
  - If drop > 0: the word is discarded and drop decrements.
  - Otherwise {rsp_pc, imem_rsp_data} is pushed and rsp_pc += 4 with wrap.
- Simultaneous request handshake and response in the same cycle: outstanding is unchanged.
- imem_rsp_valid with outstanding==0: the word is ignored; assertion failure in simulation.
- Output:
  - id_valid = (count != 0); id_inst and id_pc come from the FIFO head.
  - Pop occurs when id_valid && id_ready.
  - There is no bypass: a word pushed into an empty FIFO appears on id_* the next cycle.
  - Minimum request-to-id_valid latency = memory latency + 1.
  - Push and pop in the same cycle are allowed at any occupancy, including full; count is then unchanged.
  - id_inst and id_pc hold their values while id_valid && !id_ready.
- Redirect (redirect_valid=1), which takes priority over pop and push:
  - The FIFO is emptied (count=0), so id_valid=0 on the next cycle.
  - fetch_pc and rsp_pc are set to {redirect_pc[31:2], 2'b00}.
  - drop = outstanding_next, i.e. every in-flight request is discarded, including one whose response arrives in the redirect cycle. That response is not pushed and decrements outstanding.
  - No request is issued in the redirect cycle; fetch at the new PC starts the following cycle.
  - Back-to-back redirects: the last one wins, and drop is recomputed each time.
- Redirect while outstanding==DEPTH: new requests wait until drop responses have drained the credit.

Test Plan:
- 1-cycle memory, id_ready=1, RESET_PC=0 -> id_pc sequence 0x0, 0x4, 0x8…, with one new instruction per cycle after the initial 2-cycle latency; id_inst matches memory.
- id_ready=0 for 10 cycles, DEPTH=4 -> count reaches 4, imem_req_valid=0 once count+outstanding=4, and id_inst/id_pc hold. Release -> no lost or duplicated PC.
- 3-cycle memory, redirect_valid with redirect_pc=0x100 while 2 requests are outstanding -> both stale words dropped, next id_pc=0x100, and 0x100 is the next address with a request handshake.
- redirect_pc=0x203 -> fetch restarts at 0x200 and id_pc=0x200.
- RESET_PC=32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted mid-stream with FIFO full -> next cycle id_valid=0 and imem_req_addr=RESET_PC; fetch resumes cleanly after rst deasserts.
